// File: rtl/pattern_chk_if.sv
// Receive-path bundle between the SERDES decoder side and the pattern checker.
// The master drives the received word stream and the slave returns status.
`timescale 1ns/1ps
interface pattern_chk_if #(
    parameter int g_DATA_WID = 32,
    parameter int g_CNT_WID  = 16
);
    logic [g_DATA_WID-1:0] data_in_i;
    logic [3:0]            rx_k_char_i;
    logic                  rx_valid_i;
    logic                  clear_err_i;
    logic                  lock_o;
    logic                  err_o;
    logic [g_CNT_WID-1:0]  err_count_o;

    modport master (
        output data_in_i, rx_k_char_i, rx_valid_i, clear_err_i,
        input  lock_o, err_o, err_count_o
    );

    modport slave (
        input  data_in_i, rx_k_char_i, rx_valid_i, clear_err_i,
        output lock_o, err_o, err_count_o
    );
endinterface

// File: rtl/pattern_chk.sv
// Checker for the K28.5-preamble / incrementing-counter stream: locks onto the
// counter, flags each wrong word while locked and keeps a saturating error count.
`timescale 1ns/1ps
module pattern_chk #(
    parameter int g_DATA_WID    = 32,
    parameter int g_CNT_WID     = 16,
    parameter int g_LOSS_THRESH = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    pattern_chk_if.slave  rx
);
    typedef enum logic [1:0] {HUNT, SEED, LOCKED} state_t;

    localparam logic [g_DATA_WID-1:0] c_data_one = 1;
    localparam logic [g_CNT_WID-1:0]  c_cnt_one  = 1;
    localparam logic [7:0]            c_thresh   = g_LOSS_THRESH[7:0];

    state_t                state_q, state_d;
    logic [g_DATA_WID-1:0] seed_q, seed_d;
    logic [g_DATA_WID-1:0] expected_q, expected_d;
    logic [7:0]            consec_q, consec_d;
    logic [g_CNT_WID-1:0]  err_count_q, err_count_d;
    logic                  err_q, err_d;
    logic                  lock_q, lock_d;

    logic                  is_k;
    logic [7:0]            consec_inc;

    assign is_k       = (rx.rx_k_char_i != 4'b0000);
    assign consec_inc = consec_q + 8'd1;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d     = state_q;
        seed_d      = seed_q;
        expected_d  = expected_q;
        consec_d    = consec_q;
        err_count_d = err_count_q;
        err_d       = 1'b0;

        if (rx.rx_valid_i) begin
            case (state_q)
                HUNT: begin
                    if (!is_k) begin
                        seed_d  = rx.data_in_i;
                        state_d = SEED;
                    end
                end
                SEED: begin
                    if (is_k) begin
                        state_d = HUNT;
                    end else if (rx.data_in_i == seed_q + c_data_one) begin
                        state_d    = LOCKED;
                        expected_d = rx.data_in_i + c_data_one;
                        consec_d   = 8'd0;
                    end else begin
                        seed_d = rx.data_in_i;
                    end
                end
                LOCKED: begin
                    if (is_k) begin
                        state_d = HUNT;
                    end else begin
                        // Expected always advances so one bad word costs one error.
                        expected_d = expected_q + c_data_one;
                        if (rx.data_in_i == expected_q) begin
                            consec_d = 8'd0;
                        end else begin
                            err_d    = 1'b1;
                            consec_d = consec_inc;
                            if (err_count_q != '1) begin
                                err_count_d = err_count_q + c_cnt_one;
                            end
                            if (consec_inc == c_thresh) begin
                                state_d = HUNT;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // Clear wins over a same-cycle error; err_o still reports that word.
        if (rx.clear_err_i) begin
            err_count_d = '0;
        end

        lock_d = (state_d == LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= HUNT;
            seed_q      <= '0;
            expected_q  <= '0;
            consec_q    <= 8'd0;
            err_count_q <= '0;
            err_q       <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            expected_q  <= expected_d;
            consec_q    <= consec_d;
            err_count_q <= err_count_d;
            err_q       <= err_d;
            lock_q      <= lock_d;
        end
    end

    assign rx.lock_o      = lock_q;
    assign rx.err_o       = err_q;
    assign rx.err_count_o = err_count_q;
endmodule

// File: tb/tb_pattern_chk.sv
// Self-checking bench for pattern_chk: vector table plus hand-written stream sequences,
// with expected outputs queued at drive time and compared after the sampling edge.
`timescale 1ns/1ps
module tb_pattern_chk;
    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    always #5 clk_i = ~clk_i;

    pattern_chk_if #(.g_DATA_WID(32), .g_CNT_WID(16)) rx  ();
    pattern_chk_if #(.g_DATA_WID(32), .g_CNT_WID(4))  rx4 ();

    pattern_chk #(.g_DATA_WID(32), .g_CNT_WID(16), .g_LOSS_THRESH(8)) u_dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .rx      (rx.slave)
    );

    pattern_chk #(.g_DATA_WID(32), .g_CNT_WID(4), .g_LOSS_THRESH(8)) u_dut4 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .rx      (rx4.slave)
    );

    typedef struct {
        logic        valid;
        logic [3:0]  k;
        logic [31:0] data;
        logic        lock;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic        lock;
        logic        err;
        logic [15:0] cnt;
        bit          chk4;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] k, input logic [31:0] d, input logic clr);
        rx.rx_valid_i   = v;  rx4.rx_valid_i  = v;
        rx.rx_k_char_i  = k;  rx4.rx_k_char_i = k;
        rx.data_in_i    = d;  rx4.data_in_i   = d;
        rx.clear_err_i  = clr; rx4.clear_err_i = clr;
    endtask

    // One word in, one expected record out of the scoreboard after the edge.
    task automatic step(input string name, input logic v, input logic [3:0] k,
                        input logic [31:0] d, input logic clr, input logic el,
                        input logic ee, input logic [15:0] ec, input bit c4);
        exp_t e;
        e.name = name; e.lock = el; e.err = ee; e.cnt = ec; e.chk4 = c4;
        sb_q.push_back(e);
        drive(v, k, d, clr);
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            check({name, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            if (e.chk4) begin
                check({e.name, ".lock"}, {31'd0, rx4.lock_o}, {31'd0, e.lock});
                check({e.name, ".err"},  {31'd0, rx4.err_o},  {31'd0, e.err});
                check({e.name, ".cnt"},  {28'd0, rx4.err_count_o}, {16'd0, e.cnt});
            end else begin
                check({e.name, ".lock"}, {31'd0, rx.lock_o}, {31'd0, e.lock});
                check({e.name, ".err"},  {31'd0, rx.err_o},  {31'd0, e.err});
                check({e.name, ".cnt"},  {16'd0, rx.err_count_o}, {16'd0, e.cnt});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [11];
        logic [31:0] nxt;
        logic [15:0] c;

        // Wrap-around lock with rx_valid_i toggling low between words.
        tbl[0]  = '{1'b1, 4'h0, 32'hFFFF_FFFD, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 4'h0, 32'hFFFF_FFFE, 1'b1, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 4'h0, 32'h1234_5678, 1'b1, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 4'h0, 32'h1234_5678, 1'b1, 1'b0, 16'd0};
        tbl[6]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 4'h1, 32'h0000_00BC, 1'b1, 1'b0, 16'd0};
        tbl[8]  = '{1'b1, 4'h0, 32'h0000_0001, 1'b1, 1'b0, 16'd0};
        tbl[9]  = '{1'b1, 4'h1, 32'h0000_00BC, 1'b0, 1'b0, 16'd0};
        tbl[10] = '{1'b0, 4'h0, 32'h0000_0005, 1'b0, 1'b0, 16'd0};

        drive(1'b0, 4'h0, 32'd0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        check("reset.lock", {31'd0, rx.lock_o}, 32'd0);
        check("reset.err",  {31'd0, rx.err_o},  32'd0);
        check("reset.cnt",  {16'd0, rx.err_count_o}, 32'd0);
        #2 reset_i = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step($sformatf("wrap[%0d]", i), tbl[i].valid, tbl[i].k, tbl[i].data,
                 1'b0, tbl[i].lock, tbl[i].err, tbl[i].cnt, 1'b0);
        end

        // Generator stream: K28.5 preamble then counter 1..1000.
        for (int i = 0; i < 5; i++)
            step($sformatf("gen_k[%0d]", i), 1'b1, 4'h1, 32'h0000_00BC, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        for (int i = 1; i <= 1000; i++)
            step($sformatf("gen[%0d]", i), 1'b1, 4'h0, i, 1'b0, (i >= 2), 1'b0, 16'd0, 1'b0);

        // K word while locked drops lock silently, then a stream with word 100 corrupted.
        step("restart_k", 1'b1, 4'h1, 32'h0000_00BC, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        for (int i = 1; i <= 110; i++) begin
            if (i == 100)
                step("corrupt100", 1'b1, 4'h0, 32'hFFFF_FFEF, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
            else
                step($sformatf("s2[%0d]", i), 1'b1, 4'h0, i, 1'b0, (i >= 2), 1'b0,
                     (i > 100) ? 16'd1 : 16'd0, 1'b0);
        end

        // Clear on a matching word, then eight consecutive bad words lose lock.
        step("clr_match", 1'b1, 4'h0, 32'd111, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        for (int i = 1; i <= 8; i++)
            step($sformatf("bad[%0d]", i), 1'b1, 4'h0, 32'hA5A5_0000 + i, 1'b0,
                 (i < 8), 1'b1, 16'(i), 1'b0);
        step("relock_a", 1'b1, 4'h0, 32'd500, 1'b0, 1'b0, 1'b0, 16'd8, 1'b0);
        step("relock_b", 1'b1, 4'h0, 32'd501, 1'b0, 1'b1, 1'b0, 16'd8, 1'b0);
        step("relock_c", 1'b1, 4'h0, 32'd502, 1'b0, 1'b1, 1'b0, 16'd8, 1'b0);
        step("k_drop",   1'b1, 4'h2, 32'h0000_BC00, 1'b0, 1'b0, 1'b0, 16'd8, 1'b0);

        // Non-consecutive pair in SEED is reseeded, not counted.
        step("seed_7",  1'b1, 4'h0, 32'd7,  1'b0, 1'b0, 1'b0, 16'd8, 1'b0);
        step("seed_9",  1'b1, 4'h0, 32'd9,  1'b0, 1'b0, 1'b0, 16'd8, 1'b0);
        step("seed_10", 1'b1, 4'h0, 32'd10, 1'b0, 1'b1, 1'b0, 16'd8, 1'b0);

        // Seven misses, a match, seven more misses: the run restarts so lock holds.
        nxt = 32'd11;
        c   = 16'd8;
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 7; i++) begin
                c = c + 16'd1;
                step($sformatf("run%0d_bad[%0d]", r, i), 1'b1, 4'h0, 32'hC3C3_0000 + i,
                     1'b0, 1'b1, 1'b1, c, 1'b0);
                nxt = nxt + 32'd1;
            end
            step($sformatf("run%0d_good", r), 1'b1, 4'h0, nxt, 1'b0, 1'b1, 1'b0, c, 1'b0);
            nxt = nxt + 32'd1;
        end
        step("k_drop2", 1'b1, 4'h1, 32'h0000_00BC, 1'b0, 1'b0, 1'b0, 16'd22, 1'b0);

        // Asynchronous reset between edges while locked.
        step("pre_rst_a", 1'b1, 4'h0, 32'd200, 1'b0, 1'b0, 1'b0, 16'd22, 1'b0);
        step("pre_rst_b", 1'b1, 4'h0, 32'd201, 1'b0, 1'b1, 1'b0, 16'd22, 1'b0);
        #2 reset_i = 1'b1;
        #1;
        check("async_rst.lock", {31'd0, rx.lock_o}, 32'd0);
        check("async_rst.cnt",  {16'd0, rx.err_count_o}, 32'd0);
        #1 reset_i = 1'b0;
        step("post_rst_a", 1'b1, 4'h0, 32'd202, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        step("post_rst_b", 1'b1, 4'h0, 32'd203, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);

        // Narrow counter: 20 isolated errors saturate at 0xF, then clear vs error.
        nxt = 32'd204;
        for (int i = 1; i <= 20; i++) begin
            c = (i > 15) ? 16'd15 : 16'(i);
            step($sformatf("sat_bad[%0d]", i), 1'b1, 4'h0, 32'h5A5A_0000 + i, 1'b0,
                 1'b1, 1'b1, c, 1'b1);
            nxt = nxt + 32'd1;
            step($sformatf("sat_good[%0d]", i), 1'b1, 4'h0, nxt, 1'b0, 1'b1, 1'b0, c, 1'b1);
            nxt = nxt + 32'd1;
        end
        step("clr_vs_err", 1'b1, 4'h0, 32'h5A5A_FFFF, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1);
        step("after_clr",  1'b1, 4'h0, 32'h5A5A_FFFE, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
